// File: rtl/prog_data_memory.sv
// Program/data RAM behind the CPU memory port: clears itself after reset,
// takes a host program image over a valid/ready stream, then serves the CPU.
module prog_data_memory #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16,
  parameter int LOAD_BASE  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [DATA_WIDTH-1:0] out,
  input  logic                  ld_valid,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  ld_last,
  output logic                  ld_ready,
  output logic                  ready,
  output logic                  err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LP_BASE = (ADDR_WIDTH + 1)'(LOAD_BASE);

  typedef enum logic [1:0] {
    CLEAR,
    LOAD,
    RUN
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [ADDR_WIDTH-1:0]   cp;
  // Extra MSB marks "pointer ran off the end" so overflow never wraps.
  logic [ADDR_WIDTH:0]     lp;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    xfer;
  logic                    wr_en;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;

  always_comb begin
    state_next = state;
    ld_ready   = 1'b0;
    ready      = 1'b0;
    xfer       = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = addr;
    wr_data    = data;
    unique case (state)
      CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = cp;
        wr_data = '0;
        if (cp == '1) state_next = LOAD;
      end
      LOAD: begin
        ld_ready = 1'b1;
        xfer     = ld_valid;
        wr_en    = ld_valid && !lp[ADDR_WIDTH];
        wr_addr  = lp[ADDR_WIDTH-1:0];
        wr_data  = ld_data;
        if (ld_valid && ld_last) state_next = RUN;
      end
      RUN: begin
        ready = 1'b1;
        wr_en = we;
      end
      default: state_next = CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      cp    <= '0;
      lp    <= LP_BASE;
      err   <= 1'b0;
      out   <= '0;
    end else begin
      state <= state_next;
      if (state == CLEAR) cp <= cp + ADDR_WIDTH'(1);
      if (xfer && !lp[ADDR_WIDTH]) lp <= lp + (ADDR_WIDTH + 1)'(1);
      if (xfer && lp[ADDR_WIDTH]) err <= 1'b1;
      out <= (state == RUN) ? mem[addr] : '0;
    end
  end

  // Array has no reset; the CLEAR sequence zeroes it.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

endmodule

// File: tb/tb_prog_data_memory.sv
// Randomized bench for prog_data_memory against a behavioural memory model
// plus directed scenarios for clear length, load, overflow and mid-load reset.
module tb_prog_data_memory;

  localparam int AW    = 6;
  localparam int DW    = 16;
  localparam int BASE  = 8;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          we = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] data = '0;
  logic [DW-1:0] out;
  logic          ld_valid = 1'b0;
  logic [DW-1:0] ld_data = '0;
  logic          ld_last = 1'b0;
  logic          ld_ready;
  logic          ready;
  logic          err;

  prog_data_memory #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .LOAD_BASE (BASE)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (we),
    .addr    (addr),
    .data    (data),
    .out     (out),
    .ld_valid(ld_valid),
    .ld_data (ld_data),
    .ld_last (ld_last),
    .ld_ready(ld_ready),
    .ready   (ready),
    .err     (err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: phase 0 = clearing, 1 = loading, 2 = running
  int unsigned m_mem [DEPTH];
  int          m_phase;
  int unsigned m_cleared;
  int unsigned m_lp;
  bit          m_err;
  int unsigned m_out;

  task automatic model_reset();
    m_phase   = 0;
    m_cleared = 0;
    m_lp      = BASE;
    m_err     = 1'b0;
    m_out     = 0;
  endtask

  // Drive one cycle of inputs, advance the model over the edge, check at negedge.
  task automatic step(input string tag, input bit w, input int unsigned a, input int unsigned d,
                      input bit lv, input int unsigned ldd, input bit ll);
    int unsigned aa;
    aa       = a % DEPTH;
    we       = w;
    addr     = aa[AW-1:0];
    data     = d[DW-1:0];
    ld_valid = lv;
    ld_data  = ldd[DW-1:0];
    ld_last  = ll;
    case (m_phase)
      0: begin
        m_mem[m_cleared] = 0;
        m_cleared++;
        if (m_cleared == DEPTH) m_phase = 1;
        m_out = 0;
      end
      1: begin
        m_out = 0;
        if (lv) begin
          if (m_lp < DEPTH) begin
            m_mem[m_lp] = ldd & 32'hFFFF;
            m_lp++;
          end else begin
            m_err = 1'b1;
          end
          if (ll) m_phase = 2;
        end
      end
      default: begin
        m_out = m_mem[aa];
        if (w) m_mem[aa] = d & 32'hFFFF;
      end
    endcase
    @(negedge clk);
    check($sformatf("%s.out", tag), 32'(out), m_out);
    check($sformatf("%s.ready", tag), 32'(ready), 32'(m_phase == 2));
    check($sformatf("%s.ld_ready", tag), 32'(ld_ready), 32'(m_phase == 1));
    check($sformatf("%s.err", tag), 32'(err), 32'(m_err));
  endtask

  task automatic do_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    check($sformatf("%s.rst_out", tag), 32'(out), 0);
    check($sformatf("%s.rst_ready", tag), 32'(ready), 0);
    check($sformatf("%s.rst_ld_ready", tag), 32'(ld_ready), 0);
    check($sformatf("%s.rst_err", tag), 32'(err), 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_clear(input string tag);
    int n;
    n = 0;
    while (!ld_ready && n < 200) begin
      step("clear", $urandom_range(0, 1), $urandom, $urandom, $urandom_range(0, 1), $urandom,
           $urandom_range(0, 1));
      n++;
    end
    check($sformatf("%s.clear_len", tag), n, 64);
  endtask

  task automatic rd(input string tag, input int unsigned a, input int unsigned exp);
    step(tag, 1'b0, a, 0, 1'b0, 0, 1'b0);
    check($sformatf("%s.direct", tag), 32'(out), exp);
  endtask

  task automatic ld(input int unsigned d, input bit last);
    step("load", 1'b0, $urandom, $urandom, 1'b1, d, last);
  endtask

  initial begin
    model_reset();

    // Load two words back to back, then read them
    do_reset("r1");
    wait_clear("r1");
    ld(32'h1234, 1'b0);
    check("ld1.ready", 32'(ready), 0);
    ld(32'hABCD, 1'b1);
    check("ld2.ready", 32'(ready), 1);
    check("ld2.ld_ready", 32'(ld_ready), 0);
    rd("rd8", 8, 32'h1234);
    rd("rd9", 9, 32'hABCD);
    rd("rd7", 7, 0);
    rd("rd40", 40, 0);
    // Write then read in RUN; same-edge read returns old value
    step("wr5", 1'b1, 5, 32'h00FF, 1'b0, 0, 1'b0);
    check("wr5.old", 32'(out), 0);
    rd("rd5", 5, 32'h00FF);

    // Gapped load with a stray ld_last while not valid
    do_reset("r2");
    wait_clear("r2");
    ld(32'h0001, 1'b0);
    step("gap1", 1'b0, 0, 0, 1'b0, 0, 1'b0);
    ld(32'h0002, 1'b0);
    step("gap2", 1'b0, 0, 0, 1'b0, 32'hDEAD, 1'b1);
    check("stray_last.ready", 32'(ready), 0);
    check("stray_last.ld_ready", 32'(ld_ready), 1);
    ld(32'h0003, 1'b1);
    rd("bp8", 8, 1);
    rd("bp9", 9, 2);
    rd("bp10", 10, 3);
    rd("bp11", 11, 0);

    // Overflow: 57 words, last one dropped
    do_reset("r3");
    wait_clear("r3");
    for (int i = 0; i < 57; i++) ld(32'h0100 + i, i == 56);
    check("ovf.err", 32'(err), 1);
    check("ovf.ready", 32'(ready), 1);
    rd("ovf0", 0, 0);
    rd("ovf8", 8, 32'h0100);
    rd("ovf63", 63, 32'h0100 + 55);

    // Reset in the middle of a load
    do_reset("r4");
    wait_clear("r4");
    ld(32'hAAAA, 1'b0);
    ld(32'hBBBB, 1'b0);
    do_reset("mid");
    wait_clear("mid");
    ld(32'h5555, 1'b1);
    rd("mid8", 8, 32'h5555);
    rd("mid9", 9, 0);

    // Randomized rounds
    for (int r = 0; r < 8; r++) begin
      int nw;
      int abort_at;
      bit aborted;
      do_reset("rand");
      wait_clear("rand");
      nw       = $urandom_range(1, 70);
      abort_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, nw - 1) : -1;
      aborted  = 1'b0;
      for (int i = 0; i < nw; i++) begin
        if (i == abort_at) begin
          do_reset("rand_abort");
          wait_clear("rand_abort");
          aborted = 1'b1;
          break;
        end
        while ($urandom_range(0, 2) == 0)
          step("lgap", 1'b0, $urandom, $urandom, 1'b0, $urandom, $urandom_range(0, 1));
        ld($urandom, i == nw - 1);
      end
      if (aborted) ld($urandom, 1'b1);
      for (int c = 0; c < 150; c++)
        step("run", $urandom_range(0, 2) == 0, $urandom_range(0, 15) + (($urandom_range(0, 3) == 0) ? 48 : 0),
             $urandom, $urandom_range(0, 1), $urandom, $urandom_range(0, 1));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
